// File: rtl/pipeline_hazard_ctrl.sv
// Hazard scheduler for a 5-stage MIPS pipeline, placed beside the ID stage.
// It decodes the ID instruction, tracks in-flight destinations in EX/MEM/WB,
// and produces the stall/flush controls and the registered EX forwarding selects.
module pipeline_hazard_ctrl #(
  parameter bit FORWARDING = 1'b1,
  parameter bit WB_BYPASS  = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction_ID,
  input  logic             id_valid,
  input  logic             branch_taken_EX,
  output logic             regIF_en,
  output logic             regID_en,
  output logic             nopMux,
  output logic             flush_ID,
  output logic [1:0]       fwdA_EX,
  output logic [1:0]       fwdB_EX,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_XORI  = 6'h0E, OP_LW   = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic       use_rs, use_rt, id_ld;
  logic [4:0] id_dst;

  logic [4:0] ex_dst, mem_dst, wb_dst;
  logic       ex_ld, mem_ld;

  logic       hazard, stall, advance;
  logic       unused_bits;

  assign op    = instruction_ID[31:26];
  assign rs    = instruction_ID[25:21];
  assign rt    = instruction_ID[20:16];
  assign rd    = instruction_ID[15:11];
  assign funct = instruction_ID[5:0];

  // shamt and the MEM load flag carry no hazard information here
  assign unused_bits = ^{instruction_ID[10:6], mem_ld};

  // A destination of $0 means "none", so $0 never hits.
  function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
    return (dst != 5'd0) && (src == dst);
  endfunction

  // Forward select for one source: a non-load in EX beats MEM.
  function automatic logic [1:0] fsel(input logic used, input logic [4:0] src,
                                      input logic [4:0] exd, input logic exl,
                                      input logic [4:0] memd);
    if (!used)                   return 2'd0;
    else if (hit(src, exd) && !exl) return 2'd1;
    else if (hit(src, memd))     return 2'd2;
    else                         return 2'd0;
  endfunction

  // Decode the ID instruction into used sources and destination
  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    id_dst = 5'd0;
    id_ld  = 1'b0;
    if (id_valid) begin
      case (op)
        OP_RTYPE: begin
          use_rs = 1'b1;
          if (funct != FN_JR) begin
            use_rt = 1'b1;
            id_dst = rd;
          end
        end
        OP_LW:            begin use_rs = 1'b1; id_dst = rt; id_ld = 1'b1; end
        OP_ADDI, OP_XORI: begin use_rs = 1'b1; id_dst = rt; end
        OP_SW, OP_BEQ, OP_BNE: begin use_rs = 1'b1; use_rt = 1'b1; end
        OP_JAL:           id_dst = 5'd31;
        OP_J:             ;
        default:          ;
      endcase
    end
  end

  // RAW detection against the in-flight destinations
  always_comb begin
    hazard = 1'b0;
    if (FORWARDING) begin
      hazard = ex_ld && ((use_rs && hit(rs, ex_dst)) || (use_rt && hit(rt, ex_dst)));
    end else begin
      hazard = (use_rs && (hit(rs, ex_dst) || hit(rs, mem_dst))) ||
               (use_rt && (hit(rt, ex_dst) || hit(rt, mem_dst)));
      if (!WB_BYPASS)
        hazard = hazard || (use_rs && hit(rs, wb_dst)) || (use_rt && hit(rt, wb_dst));
    end
  end

  assign stall   = !reset && id_valid && hazard && !branch_taken_EX;
  assign advance = id_valid && !stall && !branch_taken_EX;

  // Pipeline control outputs; a taken branch overrides any stall
  always_comb begin
    regIF_en = 1'b1;
    regID_en = 1'b1;
    nopMux   = 1'b0;
    flush_ID = 1'b0;
    if (reset) begin
      regIF_en = 1'b1;
    end else if (branch_taken_EX) begin
      flush_ID = 1'b1;
      nopMux   = 1'b1;
    end else if (stall) begin
      regIF_en = 1'b0;
      regID_en = 1'b0;
      nopMux   = 1'b1;
    end
  end

  // Destination tracking, forward selects and the saturating stall counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_dst       <= '0;
      ex_ld        <= 1'b0;
      mem_dst      <= '0;
      mem_ld       <= 1'b0;
      wb_dst       <= '0;
      fwdA_EX      <= 2'd0;
      fwdB_EX      <= 2'd0;
      stall_cycles <= '0;
    end else begin
      mem_dst <= ex_dst;
      mem_ld  <= ex_ld;
      wb_dst  <= mem_dst;
      if (advance) begin
        ex_dst <= id_dst;
        ex_ld  <= id_ld;
      end else begin
        ex_dst <= '0;
        ex_ld  <= 1'b0;
      end
      if (FORWARDING && advance) begin
        fwdA_EX <= fsel(use_rs, rs, ex_dst, ex_ld, mem_dst);
        fwdB_EX <= fsel(use_rt, rt, ex_dst, ex_ld, mem_dst);
      end else begin
        fwdA_EX <= 2'd0;
        fwdB_EX <= 2'd0;
      end
      if (stall && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a forwarding instance (d1), a
// no-forwarding instance with WB bypass (d0) and a no-forwarding, no-bypass
// instance with a 2-bit counter (d2) share one stimulus stream.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        vld = 1'b0;
  logic        br = 1'b0;

  logic        d1_ifen, d1_iden, d1_nop, d1_flush;
  logic [1:0]  d1_fa, d1_fb;
  logic [15:0] d1_cnt;
  logic        d0_ifen, d0_iden, d0_nop, d0_flush;
  logic [1:0]  d0_fa, d0_fb;
  logic [15:0] d0_cnt;
  logic        d2_ifen, d2_iden, d2_nop, d2_flush;
  logic [1:0]  d2_fa, d2_fb;
  logic [1:0]  d2_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FORWARDING(1'b1), .WB_BYPASS(1'b1), .CNT_W(16)) d1 (
    .clk(clk), .reset(reset), .instruction_ID(instr), .id_valid(vld),
    .branch_taken_EX(br), .regIF_en(d1_ifen), .regID_en(d1_iden), .nopMux(d1_nop),
    .flush_ID(d1_flush), .fwdA_EX(d1_fa), .fwdB_EX(d1_fb), .stall_cycles(d1_cnt));

  pipeline_hazard_ctrl #(.FORWARDING(1'b0), .WB_BYPASS(1'b1), .CNT_W(16)) d0 (
    .clk(clk), .reset(reset), .instruction_ID(instr), .id_valid(vld),
    .branch_taken_EX(br), .regIF_en(d0_ifen), .regID_en(d0_iden), .nopMux(d0_nop),
    .flush_ID(d0_flush), .fwdA_EX(d0_fa), .fwdB_EX(d0_fb), .stall_cycles(d0_cnt));

  pipeline_hazard_ctrl #(.FORWARDING(1'b0), .WB_BYPASS(1'b0), .CNT_W(2)) d2 (
    .clk(clk), .reset(reset), .instruction_ID(instr), .id_valid(vld),
    .branch_taken_EX(br), .regIF_en(d2_ifen), .regID_en(d2_iden), .nopMux(d2_nop),
    .flush_ID(d2_flush), .fwdA_EX(d2_fa), .fwdB_EX(d2_fb), .stall_cycles(d2_cnt));

  typedef struct {
    logic [31:0] instr;
    logic        vld;
    logic        br;
    logic        en;
    logic        nop;
    logic        flush;
    logic [1:0]  fa;
    logic [1:0]  fb;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic apply(input logic [31:0] i, input logic v, input logic b);
    @(posedge clk);
    #1;
    instr = i;
    vld   = v;
    br    = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr = 32'd0;
    vld   = 1'b0;
    br    = 1'b0;
    #1;
    chk("rst_ifen", {31'd0, d1_ifen}, 32'd1);
    chk("rst_nop",  {31'd0, d1_nop},  32'd0);
    chk("rst_cnt",  {16'd0, d1_cnt},  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] add3, sub4, lw3, add4_33, addi0, add2_00, lw0, add5, add4_30, nop_i;

  initial begin
    add3    = rtype(5'd1, 5'd2, 5'd3, 6'h20);
    sub4    = rtype(5'd3, 5'd5, 5'd4, 6'h22);
    lw3     = itype(6'h23, 5'd1, 5'd3, 16'd0);
    add4_33 = rtype(5'd3, 5'd3, 5'd4, 6'h20);
    addi0   = itype(6'h08, 5'd1, 5'd0, 16'd5);
    add2_00 = rtype(5'd0, 5'd0, 5'd2, 6'h20);
    lw0     = itype(6'h23, 5'd1, 5'd0, 16'd0);
    add5    = rtype(5'd0, 5'd1, 5'd5, 6'h20);
    add4_30 = rtype(5'd3, 5'd0, 5'd4, 6'h20);
    nop_i   = 32'd0;

    // {instr, vld, br, en, nop, flush, fwdA/B of the instruction now in EX}
    tbl[0]  = '{add3,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[1]  = '{sub4,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[2]  = '{nop_i,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0};
    tbl[3]  = '{lw3,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[4]  = '{add4_33, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0};
    tbl[5]  = '{add4_33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[6]  = '{nop_i,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd2};
    tbl[7]  = '{addi0,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[8]  = '{add2_00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[9]  = '{lw0,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[10] = '{add5,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[11] = '{nop_i,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[12] = '{lw3,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[13] = '{add4_33, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0};
    tbl[14] = '{nop_i,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};

    do_reset();

    // Forwarding, load-use, $0 destinations and branch-over-stall on d1
    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].instr, tbl[i].vld, tbl[i].br);
      @(negedge clk);
      chk($sformatf("v%0d_ifen", i),  {31'd0, d1_ifen},  {31'd0, tbl[i].en});
      chk($sformatf("v%0d_iden", i),  {31'd0, d1_iden},  {31'd0, tbl[i].en});
      chk($sformatf("v%0d_nop", i),   {31'd0, d1_nop},   {31'd0, tbl[i].nop});
      chk($sformatf("v%0d_flush", i), {31'd0, d1_flush}, {31'd0, tbl[i].flush});
      chk($sformatf("v%0d_fwdA", i),  {30'd0, d1_fa},    {30'd0, tbl[i].fa});
      chk($sformatf("v%0d_fwdB", i),  {30'd0, d1_fb},    {30'd0, tbl[i].fb});
      if (i == 6) chk("cnt_after_loaduse", {16'd0, d1_cnt}, 32'd1);
    end
    chk("cnt_after_branch", {16'd0, d1_cnt}, 32'd1);

    // No-forwarding RAW: 2 stalls with WB bypass, 3 without; d2 counter saturates
    do_reset();
    for (int r = 0; r < 2; r++) begin
      apply(add3, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
        apply(add4_30, 1'b1, 1'b0);
        @(negedge clk);
        chk($sformatf("r%0d_k%0d_d0_ifen", r, k), {31'd0, d0_ifen}, (k >= 2) ? 32'd1 : 32'd0);
        chk($sformatf("r%0d_k%0d_d0_nop", r, k),  {31'd0, d0_nop},  (k >= 2) ? 32'd0 : 32'd1);
        chk($sformatf("r%0d_k%0d_d2_ifen", r, k), {31'd0, d2_ifen}, (k >= 3) ? 32'd1 : 32'd0);
        chk($sformatf("r%0d_k%0d_d0_fwd", r, k),  {28'd0, d0_fa, d0_fb}, 32'd0);
        chk($sformatf("r%0d_k%0d_d1_ifen", r, k), {31'd0, d1_ifen}, 32'd1);
      end
      chk($sformatf("r%0d_d0_cnt", r), {16'd0, d0_cnt}, (r == 0) ? 32'd2 : 32'd4);
      chk($sformatf("r%0d_d2_cnt", r), {30'd0, d2_cnt}, 32'd3);
    end

    // Reset asserted in the middle of a load-use stall
    do_reset();
    apply(lw3, 1'b1, 1'b0);
    apply(add4_33, 1'b1, 1'b0);
    @(negedge clk);
    chk("ls1_stall", {31'd0, d1_ifen}, 32'd0);
    apply(add4_33, 1'b1, 1'b0);
    apply(lw3, 1'b1, 1'b0);
    apply(add4_33, 1'b1, 1'b0);
    @(negedge clk);
    chk("ls2_stall", {31'd0, d1_ifen}, 32'd0);
    chk("ls2_cnt",   {16'd0, d1_cnt},  32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_ifen", {31'd0, d1_ifen}, 32'd1);
    chk("midrst_iden", {31'd0, d1_iden}, 32'd1);
    chk("midrst_nop",  {31'd0, d1_nop},  32'd0);
    chk("midrst_cnt",  {16'd0, d1_cnt},  32'd0);
    chk("midrst_fwd",  {28'd0, d1_fa, d1_fb}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_ifen", {31'd0, d1_ifen}, 32'd1);
    chk("post_rst_nop",  {31'd0, d1_nop},  32'd0);
    @(negedge clk);
    chk("post_rst_fwdA", {30'd0, d1_fa}, 32'd0);
    chk("post_rst_fwdB", {30'd0, d1_fb}, 32'd0);
    chk("post_rst_cnt",  {16'd0, d1_cnt}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
